bundle_counter_array: RTL and testbench

BUNDLE_COUNTER_ARRAY -- requirements
Module: bundle_counter_array

---
 rtl/hpu_pkg.sv | 19 +
 rtl/bundle_lane.sv | 73 +++++++
 rtl/bundle_counter_array.sv | 133 +++++++++++++
 tb/tb_bundle_counter_array.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/hpu_pkg.sv
// Shared types and counter-range helpers for the hypervector bundling unit.
package hpu_pkg;

   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      EMIT  = 1'b1
   } bundle_state_e;

   // Largest positive value of a w-bit two's-complement counter.
   function automatic int cnt_max(input int w);
      return (32'sd1 <<< (w - 32'sd1)) - 32'sd1;
   endfunction

   // Most negative value of a w-bit two's-complement counter.
   function automatic int cnt_min(input int w);
      return -(32'sd1 <<< (w - 32'sd1));
   endfunction

endpackage

// File: rtl/bundle_lane.sv
// One bundling lane: signed vote counter with range check and majority decode.
// Macro BUNDLE_SAT_EN selects clamping at the range limits instead of wrapping.
module bundle_lane
   import hpu_pkg::*;
#(
   parameter int W = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic accept,
   input  logic last,
   input  logic bit_in,
   input  logic tie_bit,
   output logic maj_bit,
   output logic lane_ovf
);

   localparam logic signed [W:0] MAX_C = (W+1)'(cnt_max(W));
   localparam logic signed [W:0] MIN_C = (W+1)'(cnt_min(W));
   localparam logic signed [W:0] ONE_C = (W+1)'(32'sd1);

   logic signed [W-1:0] count_r;
   logic signed [W:0]   sum_s;
   logic signed [W-1:0] upd_s;

   // One extra bit of headroom so the range check sees the true result.
   always_comb begin
      sum_s = {count_r[W-1], count_r};
      if (bit_in) begin
         sum_s = {count_r[W-1], count_r} - ONE_C;
      end else begin
         sum_s = {count_r[W-1], count_r} + ONE_C;
      end
      lane_ovf = (sum_s > MAX_C) || (sum_s < MIN_C);
`ifdef BUNDLE_SAT_EN
      if (sum_s > MAX_C) begin
         upd_s = MAX_C[W-1:0];
      end else if (sum_s < MIN_C) begin
         upd_s = MIN_C[W-1:0];
      end else begin
         upd_s = sum_s[W-1:0];
      end
`else
      upd_s = sum_s[W-1:0];
`endif
   end

   // Majority decision on the post-update value, tie lanes take tie_bit.
   always_comb begin
      maj_bit = 1'b0;
      if (upd_s[W-1]) begin
         maj_bit = 1'b1;
      end else if (upd_s == {W{1'b0}}) begin
         maj_bit = tie_bit;
      end else begin
         maj_bit = 1'b0;
      end
   end

   // Counter restarts from zero on the final vector of a bundle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r <= {W{1'b0}};
      end else if (accept && last) begin
         count_r <= {W{1'b0}};
      end else if (accept) begin
         count_r <= upd_s;
      end else begin
         count_r <= count_r;
      end
   end

endmodule

// File: rtl/bundle_counter_array.sv
// D-lane majority bundler: accumulate vectors until in_last, then emit the vote.
// Macro BUNDLE_SAT_EN (see bundle_lane) selects saturating lane counters.
module bundle_counter_array
   import hpu_pkg::*;
#(
   parameter int D = 1024,
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [D-1:0] in_bits,
   input  logic         in_last,
   input  logic [D-1:0] tie_bits,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [D-1:0] out_bits,
   output logic         out_ovf
);

   bundle_state_e state_r;
   bundle_state_e state_nxt_s;
   logic          in_ready_r;
   logic          out_valid_r;
   logic          in_ready_nxt_s;
   logic          out_valid_nxt_s;
   logic [D-1:0]  out_bits_r;
   logic          out_ovf_r;
   logic          ovf_trk_r;
   logic          accept_s;
   logic          last_acc_s;
   logic          any_ovf_s;
   logic [D-1:0]  maj_s;
   logic [D-1:0]  lane_ovf_s;

   assign accept_s   = in_valid & in_ready_r;
   assign last_acc_s = accept_s & in_last;
   assign any_ovf_s  = |lane_ovf_s;

   for (genvar i = 0; i < D; i++) begin : g_lane
      bundle_lane #(.W(W)) u_lane (
         .clk      (clk),
         .rst      (rst),
         .accept   (accept_s),
         .last     (in_last),
         .bit_in   (in_bits[i]),
         .tie_bit  (tie_bits[i]),
         .maj_bit  (maj_s[i]),
         .lane_ovf (lane_ovf_s[i])
      );
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ACCUM;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ACCUM: begin
            if (last_acc_s) begin
               state_nxt_s = EMIT;
            end else begin
               state_nxt_s = ACCUM;
            end
         end
         EMIT: begin
            if (out_ready) begin
               state_nxt_s = ACCUM;
            end else begin
               state_nxt_s = EMIT;
            end
         end
         default: state_nxt_s = ACCUM;
      endcase
   end

   // Handshake outputs are decoded from the next state and registered below.
   always_comb begin
      in_ready_nxt_s  = 1'b0;
      out_valid_nxt_s = 1'b0;
      case (state_nxt_s)
         ACCUM:   in_ready_nxt_s  = 1'b1;
         EMIT:    out_valid_nxt_s = 1'b1;
         default: in_ready_nxt_s  = 1'b0;
      endcase
   end

   // Registered handshake outputs; in_ready stays low until the first edge out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
      end else begin
         in_ready_r  <= in_ready_nxt_s;
         out_valid_r <= out_valid_nxt_s;
      end
   end

   // Result capture and overflow tracking, both restart on the last accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_bits_r <= {D{1'b0}};
         out_ovf_r  <= 1'b0;
         ovf_trk_r  <= 1'b0;
      end else if (last_acc_s) begin
         out_bits_r <= maj_s;
         out_ovf_r  <= ovf_trk_r | any_ovf_s;
         ovf_trk_r  <= 1'b0;
      end else if (accept_s) begin
         out_bits_r <= out_bits_r;
         out_ovf_r  <= out_ovf_r;
         ovf_trk_r  <= ovf_trk_r | any_ovf_s;
      end else begin
         out_bits_r <= out_bits_r;
         out_ovf_r  <= out_ovf_r;
         ovf_trk_r  <= ovf_trk_r;
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_bits  = out_bits_r;
   assign out_ovf   = out_ovf_r;

endmodule

// File: tb/tb_bundle_counter_array.sv
// Self-checking bench for bundle_counter_array (D=8, W=4), default or BUNDLE_SAT_EN build.
module tb_bundle_counter_array;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_bits;
   logic       in_last;
   logic [7:0] tie_bits;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_bits;
   logic       out_ovf;

   int n_checks = 0;
   int n_errors = 0;
   bit cmp_en   = 1'b0;

   // Behavioural model: plain integer vote counts per lane.
   int         m_cnt [8];
   bit         m_trk;
   bit         m_emit;
   logic       m_rdy;
   logic       m_vld;
   logic [7:0] m_bits;
   logic       m_oovf;

   bundle_counter_array #(.D(8), .W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_bits   (in_bits),
      .in_last   (in_last),
      .tie_bits  (tie_bits),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_bits  (out_bits),
      .out_ovf   (out_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_cnt[i] = 0;
      m_trk  = 1'b0;
      m_emit = 1'b0;
      m_rdy  = 1'b0;
      m_vld  = 1'b0;
      m_bits = 8'h00;
      m_oovf = 1'b0;
   endtask

   task automatic model_step();
      int  nv;
      bit  acc;
      logic [7:0] res;
      if (rst) return;
      acc = in_valid && m_rdy;
      res = 8'h00;
      if (!m_emit) begin
         if (acc) begin
            for (int i = 0; i < 8; i++) begin
               nv = m_cnt[i] + (in_bits[i] ? -1 : 1);
               if (nv > 7 || nv < -8) m_trk = 1'b1;
`ifdef BUNDLE_SAT_EN
               if (nv > 7) nv = 7;
               if (nv < -8) nv = -8;
`else
               if (nv > 7) nv = nv - 16;
               if (nv < -8) nv = nv + 16;
`endif
               m_cnt[i] = nv;
               res[i] = (nv < 0) ? 1'b1 : ((nv > 0) ? 1'b0 : tie_bits[i]);
            end
            if (in_last) begin
               m_bits = res;
               m_oovf = m_trk;
               m_trk  = 1'b0;
               for (int i = 0; i < 8; i++) m_cnt[i] = 0;
               m_emit = 1'b1;
            end
         end
      end else if (out_ready) begin
         m_emit = 1'b0;
      end
      m_rdy = !m_emit;
      m_vld = m_emit;
   endtask

   // One clock: drive inputs, advance the model at the edge, return on the falling edge.
   task automatic cyc(input logic v, input logic [7:0] b, input logic l,
                      input logic [7:0] t, input logic ordy);
      in_valid  = v;
      in_bits   = b;
      in_last   = l;
      tie_bits  = t;
      out_ready = ordy;
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("in_ready",  {7'd0, in_ready},  {7'd0, m_rdy});
         chk("out_valid", {7'd0, out_valid}, {7'd0, m_vld});
         chk("out_bits",  out_bits,          m_bits);
         chk("out_ovf",   {7'd0, out_ovf},   {7'd0, m_oovf});
      end
   end

   initial begin
      clk = 1'b0; rst = 1'b1;
      in_valid = 1'b0; in_bits = 8'h00; in_last = 1'b0; tie_bits = 8'h00; out_ready = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      cmp_en = 1'b1;
      chk("rst_in_ready", {7'd0, in_ready}, 8'h00);
      rst = 1'b0;
      cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      chk("ready_after_rst", {7'd0, in_ready}, 8'h01);

      // Three-vector majority.
      cyc(1'b1, 8'h0F, 1'b0, 8'h00, 1'b0);
      cyc(1'b1, 8'h0F, 1'b0, 8'h00, 1'b0);
      cyc(1'b1, 8'hF0, 1'b1, 8'h00, 1'b0);
      chk("t1_valid", {7'd0, out_valid}, 8'h01);
      chk("t1_bits", out_bits, 8'h0F);
      chk("t1_ovf", {7'd0, out_ovf}, 8'h00);
      cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

      // All lanes tie.
      cyc(1'b1, 8'hFF, 1'b0, 8'h00, 1'b0);
      cyc(1'b1, 8'h00, 1'b1, 8'hA5, 1'b0);
      chk("t2_bits", out_bits, 8'hA5);
      cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

      // Nine increments past the +7 limit.
      for (int k = 0; k < 9; k++) cyc(1'b1, 8'h00, (k == 8) ? 1'b1 : 1'b0, 8'h00, 1'b0);
      chk("t3_ovf", {7'd0, out_ovf}, 8'h01);
`ifdef BUNDLE_SAT_EN
      chk("t3_bits_sat", out_bits, 8'h00);
`else
      chk("t3_bits_wrap", out_bits, 8'hFF);
`endif
      cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

      // Back-pressure: single-vector bundle held for five cycles.
      cyc(1'b1, 8'h55, 1'b1, 8'h00, 1'b0);
      for (int k = 0; k < 5; k++) begin
         cyc(1'b1, 8'hFF, 1'b1, 8'hFF, 1'b0);
         chk("t4_hold_bits", out_bits, 8'h55);
         chk("t4_hold_ready", {7'd0, in_ready}, 8'h00);
         chk("t4_hold_valid", {7'd0, out_valid}, 8'h01);
      end
      cyc(1'b1, 8'hFF, 1'b1, 8'hFF, 1'b1);
      chk("t4_ready_back", {7'd0, in_ready}, 8'h01);
      chk("t4_valid_drop", {7'd0, out_valid}, 8'h00);
      cyc(1'b1, 8'h0F, 1'b1, 8'h00, 1'b0);
      chk("t4_fresh_bits", out_bits, 8'h0F);
      cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

      // Asynchronous reset mid-bundle.
      cyc(1'b1, 8'hFF, 1'b0, 8'h00, 1'b0);
      cyc(1'b1, 8'hFF, 1'b0, 8'h00, 1'b0);
      #2 rst = 1'b1;
      model_reset();
      #1;
      chk("t5_rst_bits", out_bits, 8'h00);
      chk("t5_rst_ready", {7'd0, in_ready}, 8'h00);
      chk("t5_rst_valid", {7'd0, out_valid}, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      cyc(1'b1, 8'h3C, 1'b1, 8'h00, 1'b0);
      chk("t5_fresh_bits", out_bits, 8'h3C);
      cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

      // Gapped input with in_last on idle cycles.
      cyc(1'b1, 8'h03, 1'b0, 8'h00, 1'b0);
      cyc(1'b0, 8'hFF, 1'b1, 8'hFF, 1'b0);
      chk("t6_no_emit", {7'd0, out_valid}, 8'h00);
      cyc(1'b1, 8'h03, 1'b0, 8'h00, 1'b0);
      cyc(1'b0, 8'hF0, 1'b1, 8'hF0, 1'b0);
      cyc(1'b1, 8'h01, 1'b1, 8'h02, 1'b0);
      chk("t6_bits", out_bits, 8'h03);
      chk("t6_valid", {7'd0, out_valid}, 8'h01);
      cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

      cmp_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
